// File: rtl/calc1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc1_pkg
// Purpose  : Shared calc1 command/response codes, driver FSM states and the
//            queued-operation record used by calc1_req_driver.
// Revision : 1.0 - initial release
// ============================================================================
package calc1_pkg;

    localparam logic [0:3] CMD_NOP = 4'd0;
    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
    localparam logic [0:3] CMD_SHL = 4'd5;
    localparam logic [0:3] CMD_SHR = 4'd6;

    localparam logic [0:1] RESP_NONE = 2'd0;
    localparam logic [0:1] RESP_OK   = 2'd1;
    localparam logic [0:1] RESP_OVF  = 2'd2;
    localparam logic [0:1] RESP_INV  = 2'd3;

    localparam int DRV_STATE_W = 2;

    typedef enum logic [DRV_STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND1 = 2'd1,
        ST_SEND2 = 2'd2,
        ST_WAIT  = 2'd3
    } drv_state_t;

    typedef struct packed {
        logic [0:3]  cmd;
        logic [0:31] d1;
        logic [0:31] d2;
    } op_t;

endpackage
`default_nettype wire

// File: rtl/calc1_req_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : calc1_req_driver_if
// Purpose  : Stimulus-side operation port, calc1 request/response bus and
//            completion reporting of one calc1_req_driver.
// Revision : 1.0 - initial release
// ============================================================================
interface calc1_req_driver_if;
    logic        op_valid;
    logic        op_ready;
    logic [0:3]  op_cmd;
    logic [0:31] op_data1;
    logic [0:31] op_data2;
    logic [0:3]  req_cmd_out;
    logic [0:31] req_data_out;
    logic [0:1]  resp_in;
    logic [0:31] data_in;
    logic        done;
    logic [0:3]  done_cmd;
    logic [0:1]  done_resp;
    logic [0:31] done_data;
    logic        stray_resp;
    logic        timeout;
    logic        busy;

    // master: the driver itself; slave: stimulus source plus calc1 port
    modport master (
        input  op_valid, op_cmd, op_data1, op_data2, resp_in, data_in,
        output op_ready, req_cmd_out, req_data_out, done, done_cmd,
               done_resp, done_data, stray_resp, timeout, busy
    );
    modport slave (
        output op_valid, op_cmd, op_data1, op_data2, resp_in, data_in,
        input  op_ready, req_cmd_out, req_data_out, done, done_cmd,
               done_resp, done_data, stray_resp, timeout, busy
    );
endinterface
`default_nettype wire

// File: rtl/calc1_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : calc1_req_fifo
// Purpose  : DEPTH x WIDTH synchronous FIFO; pushes are refused while full.
// Revision : 1.0 - initial release
// ============================================================================
module calc1_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/calc1_req_driver.sv
`default_nettype none
// ============================================================================
// Module   : calc1_req_driver
// Purpose  : Per-port calc1 request sequencer: queues operations and drives
//            them onto the calc1 bus, one outstanding at a time.
//            Optional macro CALC1_DRV_TIMEOUT_EN abandons ops after TIMEOUT
//            WAIT cycles without a response.
// Revision : 1.0 - initial release
// ============================================================================
module calc1_req_driver
    import calc1_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input wire logic           c_clk,
    input wire logic           reset,
    calc1_req_driver_if.master bus
);
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("calc1_req_driver: DEPTH must be a power of two >= 2");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("calc1_req_driver: TIMEOUT must be >= 1");
        end
    endgenerate

    drv_state_t  r_state, w_state_nxt;
    op_t         r_hold, w_push_op, w_fifo_rdata;
    logic        w_fifo_full, w_fifo_empty;
    logic        w_pop, w_nop_done, w_resp_hit, w_stray, w_to_expire;
    logic [0:3]  w_req_cmd,  r_req_cmd;
    logic [0:31] w_req_data, r_req_data;
    logic        r_done, r_stray, r_timeout;
    logic [0:3]  r_done_cmd;
    logic [0:1]  r_done_resp;
    logic [0:31] r_done_data;

    assign w_push_op = '{cmd: bus.op_cmd, d1: bus.op_data1, d2: bus.op_data2};

    calc1_req_fifo #(.DEPTH(DEPTH), .WIDTH($bits(op_t))) u_fifo (
        .clk     (c_clk),
        .rst     (reset),
        .i_push  (bus.op_valid),
        .i_wdata (w_push_op),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef CALC1_DRV_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Holds the number of WAIT cycles already elapsed; zero on WAIT entry
    always_ff @(posedge c_clk) begin
        if (reset || r_state != ST_WAIT) r_to_cnt <= '0;
        else                             r_to_cnt <= r_to_cnt + TO_W'(1);
    end
    assign w_to_expire = (r_state == ST_WAIT) && (bus.resp_in == RESP_NONE) &&
                         (r_to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign w_to_expire = 1'b0;
`endif

    always_ff @(posedge c_clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!w_fifo_empty && w_fifo_rdata.cmd != CMD_NOP) w_state_nxt = ST_SEND1;
            ST_SEND1: w_state_nxt = ST_SEND2;
            ST_SEND2: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_resp_hit || w_to_expire) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus values follow the current state and are registered, so the bus lags the FSM by one cycle
    always_comb begin
        w_req_cmd  = '0;
        w_req_data = '0;
        w_pop      = (r_state == ST_IDLE) && !w_fifo_empty;
        w_nop_done = w_pop && (w_fifo_rdata.cmd == CMD_NOP);
        w_resp_hit = (r_state == ST_WAIT) && (bus.resp_in != RESP_NONE);
        w_stray    = (r_state != ST_WAIT) && (bus.resp_in != RESP_NONE);
        case (r_state)
            ST_SEND1: begin
                w_req_cmd  = r_hold.cmd;
                w_req_data = r_hold.d1;
            end
            ST_SEND2: w_req_data = r_hold.d2;
            default:  ;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_hold      <= '0;
            r_req_cmd   <= '0;
            r_req_data  <= '0;
            r_done      <= 1'b0;
            r_stray     <= 1'b0;
            r_timeout   <= 1'b0;
            r_done_cmd  <= '0;
            r_done_resp <= '0;
            r_done_data <= '0;
        end else begin
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_stray    <= w_stray;
            r_req_cmd  <= w_req_cmd;
            r_req_data <= w_req_data;
            if (w_pop) r_hold <= w_fifo_rdata;
            if (w_nop_done) begin
                r_done      <= 1'b1;
                r_done_cmd  <= CMD_NOP;
                r_done_resp <= RESP_NONE;
                r_done_data <= '0;
            end else if (w_resp_hit) begin
                r_done      <= 1'b1;
                r_done_cmd  <= r_hold.cmd;
                r_done_resp <= bus.resp_in;
                r_done_data <= bus.data_in;
            end else if (w_to_expire) begin
                r_done      <= 1'b1;
                r_timeout   <= 1'b1;
                r_done_cmd  <= r_hold.cmd;
                r_done_resp <= RESP_NONE;
                r_done_data <= '0;
            end
        end
    end

    assign bus.op_ready     = !w_fifo_full;
    assign bus.busy         = (r_state != ST_IDLE) || !w_fifo_empty;
    assign bus.req_cmd_out  = r_req_cmd;
    assign bus.req_data_out = r_req_data;
    assign bus.done         = r_done;
    assign bus.done_cmd     = r_done_cmd;
    assign bus.done_resp    = r_done_resp;
    assign bus.done_data    = r_done_data;
    assign bus.stray_resp   = r_stray;
    assign bus.timeout      = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_calc1_req_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc1_req_driver
// Purpose  : Self-checking bench for calc1_req_driver (table of single ops plus
//            directed fill / reset / stray / timeout sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc1_req_driver;
    import calc1_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    calc1_req_driver_if u_if ();

    calc1_req_driver #(.DEPTH(4), .TIMEOUT(64)) dut (
        .c_clk (clk),
        .reset (rst),
        .bus   (u_if)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] d1;
        logic [31:0] d2;
        int          delay;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        u_if.op_valid = 1'b1;
        u_if.op_cmd   = v.cmd;
        u_if.op_data1 = v.d1;
        u_if.op_data2 = v.d2;
        tick();
        u_if.op_valid = 1'b0;
        check({p, " busy_after_push"}, 32'(u_if.busy), 32'd1);
        tick();
        if (v.cmd == 4'd0) begin
            check({p, " nop_done"}, 32'(u_if.done), 32'd1);
            check({p, " nop_bus_cmd"}, 32'(u_if.req_cmd_out), 32'd0);
            check({p, " nop_done_cmd"}, 32'(u_if.done_cmd), 32'd0);
            check({p, " nop_done_resp"}, 32'(u_if.done_resp), 32'(v.exp_resp));
            check({p, " nop_done_data"}, u_if.done_data, v.exp_data);
            check({p, " nop_busy"}, 32'(u_if.busy), 32'd0);
            tick();
            check({p, " nop_done_clear"}, 32'(u_if.done), 32'd0);
            check({p, " nop_bus_data"}, u_if.req_data_out, 32'd0);
        end else begin
            check({p, " pre_send_cmd"}, 32'(u_if.req_cmd_out), 32'd0);
            tick();
            check({p, " send1_cmd"}, 32'(u_if.req_cmd_out), 32'(v.cmd));
            check({p, " send1_data"}, u_if.req_data_out, v.d1);
            tick();
            check({p, " send2_cmd"}, 32'(u_if.req_cmd_out), 32'd0);
            check({p, " send2_data"}, u_if.req_data_out, v.d2);
            repeat (v.delay) tick();
            check({p, " no_early_done"}, 32'(u_if.done), 32'd0);
            u_if.resp_in = v.resp;
            u_if.data_in = v.rdata;
            tick();
            u_if.resp_in = 2'd0;
            u_if.data_in = 32'd0;
            check({p, " done"}, 32'(u_if.done), 32'd1);
            check({p, " done_cmd"}, 32'(u_if.done_cmd), 32'(v.cmd));
            check({p, " done_resp"}, 32'(u_if.done_resp), 32'(v.exp_resp));
            check({p, " done_data"}, u_if.done_data, v.exp_data);
            check({p, " wait_bus_data"}, u_if.req_data_out, 32'd0);
            tick();
            check({p, " done_clear"}, 32'(u_if.done), 32'd0);
            check({p, " idle_busy"}, 32'(u_if.busy), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int saw_done;

        //          cmd  d1            d2    delay resp  rdata         exp_resp exp_data
        vecs[0] = '{4'd1, 32'h5,        32'h3,  2, 2'd1, 32'h8,        2'd1, 32'h8};
        vecs[1] = '{4'd2, 32'hA,        32'h3,  0, 2'd1, 32'h7,        2'd1, 32'h7};
        vecs[2] = '{4'd0, 32'hFFFFFFFF, 32'h1,  0, 2'd3, 32'hDEAD,     2'd0, 32'h0};
        vecs[3] = '{4'd1, 32'hFFFFFFFF, 32'h1,  1, 2'd2, 32'h0,        2'd2, 32'h0};
        vecs[4] = '{4'd9, 32'h1,        32'h1,  4, 2'd3, 32'h0,        2'd3, 32'h0};
        vecs[5] = '{4'd5, 32'h1,        32'h1F, 3, 2'd1, 32'h80000000, 2'd1, 32'h80000000};

        rst           = 1'b1;
        u_if.op_valid = 1'b0;
        u_if.op_cmd   = 4'd0;
        u_if.op_data1 = 32'd0;
        u_if.op_data2 = 32'd0;
        u_if.resp_in  = 2'd0;
        u_if.data_in  = 32'd0;
        repeat (3) tick();

        check("rst op_ready", 32'(u_if.op_ready), 32'd1);
        check("rst busy", 32'(u_if.busy), 32'd0);
        check("rst done", 32'(u_if.done), 32'd0);
        check("rst req_cmd", 32'(u_if.req_cmd_out), 32'd0);
        check("rst req_data", u_if.req_data_out, 32'd0);
        check("rst done_data", u_if.done_data, 32'd0);
        check("rst stray", 32'(u_if.stray_resp), 32'd0);
        check("rst timeout", 32'(u_if.timeout), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_op(vecs[i], i);

        // Response while idle is flagged and ignored
        u_if.resp_in = 2'd3;
        u_if.data_in = 32'h1234;
        tick();
        u_if.resp_in = 2'd0;
        u_if.data_in = 32'd0;
        check("idle stray", 32'(u_if.stray_resp), 32'd1);
        check("idle stray no_done", 32'(u_if.done), 32'd0);
        tick();
        check("idle stray clear", 32'(u_if.stray_resp), 32'd0);

        // Response during SEND1, then a real one in WAIT
        u_if.op_valid = 1'b1;
        u_if.op_cmd   = CMD_SUB;
        u_if.op_data1 = 32'h9;
        u_if.op_data2 = 32'h4;
        tick();
        u_if.op_valid = 1'b0;
        tick();
        u_if.resp_in = 2'd2;
        u_if.data_in = 32'h55;
        tick();
        u_if.resp_in = 2'd0;
        u_if.data_in = 32'd0;
        check("s1 stray", 32'(u_if.stray_resp), 32'd1);
        check("s1 bus_cmd", 32'(u_if.req_cmd_out), 32'(CMD_SUB));
        check("s1 no_done", 32'(u_if.done), 32'd0);
        tick();
        check("s1 stray clear", 32'(u_if.stray_resp), 32'd0);
        check("s1 send2_data", u_if.req_data_out, 32'h4);
        u_if.resp_in = 2'd2;
        u_if.data_in = 32'd0;
        tick();
        u_if.resp_in = 2'd0;
        check("s1 done", 32'(u_if.done), 32'd1);
        check("s1 done_resp", 32'(u_if.done_resp), 32'd2);
        check("s1 done_data", u_if.done_data, 32'd0);
        check("s1 done_cmd", 32'(u_if.done_cmd), 32'(CMD_SUB));
        check("s1 wait_no_stray", 32'(u_if.stray_resp), 32'd0);
        tick();

        // Fill: one op in flight plus DEPTH queued, sixth refused
        u_if.op_valid = 1'b1;
        u_if.op_cmd   = CMD_ADD;
        u_if.op_data1 = 32'h11;
        u_if.op_data2 = 32'h22;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill ready_op%0d", i + 1), 32'(u_if.op_ready), 32'd1);
            tick();
        end
        check("fill ready_op6", 32'(u_if.op_ready), 32'd0);
        check("fill busy", 32'(u_if.busy), 32'd1);
        tick();
        u_if.op_valid = 1'b0;
        check("fill still_full", 32'(u_if.op_ready), 32'd0);
`ifndef CALC1_DRV_TIMEOUT_EN
        saw_done = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (u_if.done || u_if.timeout) saw_done = 1;
        end
        check("no_macro wait_persists", 32'(saw_done), 32'd0);
        check("no_macro busy", 32'(u_if.busy), 32'd1);
`endif

        // Reset during SEND2 with two ops queued
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        u_if.op_valid = 1'b1;
        u_if.op_cmd   = CMD_ADD;
        u_if.op_data1 = 32'hA1;
        u_if.op_data2 = 32'hB2;
        repeat (3) tick();
        u_if.op_valid = 1'b0;
        check("rmid send1_cmd", 32'(u_if.req_cmd_out), 32'(CMD_ADD));
        check("rmid ready_pre", 32'(u_if.op_ready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid bus_cmd", 32'(u_if.req_cmd_out), 32'd0);
        check("rmid bus_data", u_if.req_data_out, 32'd0);
        check("rmid busy", 32'(u_if.busy), 32'd0);
        check("rmid op_ready", 32'(u_if.op_ready), 32'd1);
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (u_if.done) saw_done = 1;
            tick();
        end
        check("rmid no_done", 32'(saw_done), 32'd0);
        check("rmid idle", 32'(u_if.busy), 32'd0);

`ifdef CALC1_DRV_TIMEOUT_EN
        // Op X times out on its 64th WAIT cycle; op Y answers on its 64th
        u_if.op_valid = 1'b1;
        u_if.op_cmd   = CMD_ADD;
        u_if.op_data1 = 32'h1;
        u_if.op_data2 = 32'h2;
        tick();
        u_if.op_cmd   = CMD_SUB;
        u_if.op_data1 = 32'h7;
        u_if.op_data2 = 32'h3;
        tick();
        u_if.op_valid = 1'b0;
        repeat (2) tick();
        repeat (63) tick();
        check("to early_done", 32'(u_if.done), 32'd0);
        check("to early_timeout", 32'(u_if.timeout), 32'd0);
        tick();
        check("to done", 32'(u_if.done), 32'd1);
        check("to timeout", 32'(u_if.timeout), 32'd1);
        check("to done_resp", 32'(u_if.done_resp), 32'd0);
        check("to done_data", u_if.done_data, 32'd0);
        check("to done_cmd", 32'(u_if.done_cmd), 32'(CMD_ADD));
        tick();
        check("to timeout_clear", 32'(u_if.timeout), 32'd0);
        tick();
        check("to next_cmd", 32'(u_if.req_cmd_out), 32'(CMD_SUB));
        tick();
        repeat (63) tick();
        u_if.resp_in = 2'd1;
        u_if.data_in = 32'h4;
        tick();
        u_if.resp_in = 2'd0;
        u_if.data_in = 32'd0;
        check("to race done", 32'(u_if.done), 32'd1);
        check("to race no_timeout", 32'(u_if.timeout), 32'd0);
        check("to race resp", 32'(u_if.done_resp), 32'd1);
        check("to race data", u_if.done_data, 32'h4);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
